i2s_codec_if: RTL and testbench

I2S_CODEC_IF -- requirements
Module: i2s_codec_if

---
 rtl/i2s_codec_if_pkg.sv | 22 ++
 rtl/i2s_codec_if_if.sv | 48 ++++
 rtl/i2s_bit_timer.sv | 98 +++++++++
 rtl/i2s_codec_if.sv | 178 +++++++++++++++++
 tb/tb_i2s_codec_if.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_codec_if_pkg.sv
// -----------------------------------------------------------------------------
// i2s_codec_if_pkg
// Shared constants and types for the I2S codec interface block.
//   BCLK_DIV   : clk_n cycles per BCLK period (even, >= 4)
//   SLOT_BITS  : BCLK periods per channel slot (frame = 2*SLOT_BITS)
//   WORD_BITS  : sample width, at most SLOT_BITS-1
//   FRAME_CLKS : clk_n cycles per full left+right frame
//   state_e    : controller state encoding (IDLE / RUN)
// -----------------------------------------------------------------------------
package i2s_codec_if_pkg;

   localparam int BCLK_DIV   = 6;
   localparam int SLOT_BITS  = 128;
   localparam int WORD_BITS  = 16;
   localparam int FRAME_CLKS = BCLK_DIV * 2 * SLOT_BITS;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/i2s_codec_if_if.sv
// -----------------------------------------------------------------------------
// i2s_codec_if_if
// Parallel sample bus between the I2S codec interface and the audio datapath.
//   rx_left/rx_right : last captured ADC sample pair
//   rx_valid         : one-cycle strobe, a new rx pair is present this cycle
//   tx_left/tx_right : DAC sample pair offered by the datapath
//   tx_ready         : one-cycle strobe, tx pair was latched this cycle
//
// Strobe semantics: there is no back-pressure in either direction. rx_valid
// qualifies rx_left/rx_right for exactly the cycle it is high (the registers
// then hold until the next strobe). tx_ready marks the cycle in which the
// block copies tx_left/tx_right; the datapath must present the next pair
// before the following tx_ready, one frame later.
// -----------------------------------------------------------------------------
interface i2s_codec_if_if
   import i2s_codec_if_pkg::*;
#(
   parameter int WORD_BITS = i2s_codec_if_pkg::WORD_BITS
);

   logic [WORD_BITS-1:0] rx_left;
   logic [WORD_BITS-1:0] rx_right;
   logic                 rx_valid;
   logic [WORD_BITS-1:0] tx_left;
   logic [WORD_BITS-1:0] tx_right;
   logic                 tx_ready;

   // Codec-interface side.
   modport master (
      output rx_left,
      output rx_right,
      output rx_valid,
      output tx_ready,
      input  tx_left,
      input  tx_right
   );

   // Audio datapath side.
   modport slave (
      input  rx_left,
      input  rx_right,
      input  rx_valid,
      input  tx_ready,
      output tx_left,
      output tx_right
   );

endinterface

// File: rtl/i2s_bit_timer.sv
// -----------------------------------------------------------------------------
// i2s_bit_timer
// Owns the phase counter (ph) and bit counter (bc) and derives the I2S clocks.
//   clk_n         in  : master clock, registers update on falling edge
//   rst           in  : synchronous active-high reset
//   clr_i         in  : force idle values (ph=0, bc=0, bclk=0, lrck=1)
//   adv_i         in  : advance the counters this cycle
//   bclk_o        out : registered BCLK (0 for ph < BCLK_DIV/2)
//   lrck_o        out : registered LRCK (1 while bc is in the right slot)
//   bc_o          out : current bit counter
//   bc_nxt_o      out : bit counter value after the coming edge
//   bclk_rise_o   out : coming edge makes ph = BCLK_DIV/2 (BCLK rises)
//   bclk_fall_o   out : coming edge wraps ph to 0 (BCLK falls, bc steps)
//   frame_start_o out : coming edge wraps bc to 0
// The strobes describe the next clk_n edge so the parent can register data
// in lock-step with bclk/lrck.
// -----------------------------------------------------------------------------
module i2s_bit_timer
   import i2s_codec_if_pkg::*;
#(
   parameter int BCLK_DIV  = i2s_codec_if_pkg::BCLK_DIV,
   parameter int SLOT_BITS = i2s_codec_if_pkg::SLOT_BITS,
   parameter int BC_W      = $clog2(2 * SLOT_BITS)
) (
   input  logic            clk_n,
   input  logic            rst,
   input  logic            clr_i,
   input  logic            adv_i,
   output logic            bclk_o,
   output logic            lrck_o,
   output logic [BC_W-1:0] bc_o,
   output logic [BC_W-1:0] bc_nxt_o,
   output logic            bclk_rise_o,
   output logic            bclk_fall_o,
   output logic            frame_start_o
);

   localparam int PH_W = $clog2(BCLK_DIV);

   localparam logic [PH_W-1:0] PH_LAST     = PH_W'(BCLK_DIV - 1);
   localparam logic [PH_W-1:0] PH_HALF     = PH_W'(BCLK_DIV / 2);
   localparam logic [PH_W-1:0] PH_PRE_RISE = PH_W'(BCLK_DIV / 2 - 1);
   localparam logic [BC_W-1:0] BC_LAST     = BC_W'(2 * SLOT_BITS - 1);
   localparam logic [BC_W-1:0] BC_SLOT     = BC_W'(SLOT_BITS);

   logic [PH_W-1:0] ph_q, ph_d;
   logic [BC_W-1:0] bc_q, bc_d;
   logic            bclk_q, bclk_d;
   logic            lrck_q, lrck_d;
   logic            ph_wrap;

   assign ph_wrap = adv_i & (ph_q == PH_LAST);

   always_comb begin
      ph_d   = ph_q;
      bc_d   = bc_q;
      bclk_d = 1'b0;
      lrck_d = 1'b1;
      if (clr_i) begin
         ph_d = '0;
         bc_d = '0;
      end else begin
         if (adv_i) begin
            ph_d = ph_wrap ? '0 : ph_q + 1'b1;
            if (ph_wrap) begin
               bc_d = (bc_q == BC_LAST) ? '0 : bc_q + 1'b1;
            end
         end
         // Both clocks are functions of the next counter values, so lrck
         // can only move together with a BCLK falling edge.
         bclk_d = (ph_d >= PH_HALF);
         lrck_d = (bc_d >= BC_SLOT);
      end
   end

   always_ff @(negedge clk_n) begin
      if (rst) begin
         ph_q   <= '0;
         bc_q   <= '0;
         bclk_q <= 1'b0;
         lrck_q <= 1'b1;
      end else begin
         ph_q   <= ph_d;
         bc_q   <= bc_d;
         bclk_q <= bclk_d;
         lrck_q <= lrck_d;
      end
   end

   assign bclk_o        = bclk_q;
   assign lrck_o        = lrck_q;
   assign bc_o          = bc_q;
   assign bc_nxt_o      = bc_d;
   assign bclk_rise_o   = adv_i & (ph_q == PH_PRE_RISE);
   assign bclk_fall_o   = ph_wrap;
   assign frame_start_o = ph_wrap & (bc_q == BC_LAST);

endmodule

// File: rtl/i2s_codec_if.sv
// -----------------------------------------------------------------------------
// i2s_codec_if
// I2S master for a codec running in slave mode: generates BCLK/LRCK from the
// codec master clock, serialises a DAC sample pair per frame and captures an
// ADC sample pair per frame (standard I2S, MSB one BCLK after LRCK changes).
//   clk_n       in  : codec master clock, all registers on its falling edge
//   rst         in  : synchronous active-high reset
//   init_done   in  : codec configuration complete; low forces IDLE
//   bclk        out : I2S bit clock
//   lrck        out : ADCLRCK/DACLRCK, 0 = left slot, 1 = right slot
//   adcdat      in  : serial ADC data
//   dacdat      out : serial DAC data
//   smp         if  : parallel sample bus (master modport)
//   dbg_state_o out : controller state
// Parameter constraints: BCLK_DIV even and >= 4, WORD_BITS <= SLOT_BITS-1.
// -----------------------------------------------------------------------------
module i2s_codec_if
   import i2s_codec_if_pkg::*;
#(
   parameter int BCLK_DIV  = i2s_codec_if_pkg::BCLK_DIV,
   parameter int SLOT_BITS = i2s_codec_if_pkg::SLOT_BITS,
   parameter int WORD_BITS = i2s_codec_if_pkg::WORD_BITS
) (
   input  logic           clk_n,
   input  logic           rst,
   input  logic           init_done,
   output logic           bclk,
   output logic           lrck,
   input  logic           adcdat,
   output logic           dacdat,
   i2s_codec_if_if.master smp,
   output state_e         dbg_state_o
);

   localparam int BC_W = $clog2(2 * SLOT_BITS);

   localparam logic [BC_W-1:0] SLOT_V = BC_W'(SLOT_BITS);
   localparam logic [BC_W-1:0] WORD_V = BC_W'(WORD_BITS);

   state_e                state_q, state_d;
   logic                  clr, adv;
   logic [BC_W-1:0]       bc, bc_nxt, k_cur, k_nxt;
   logic                  bclk_rise, bclk_fall, frame_start;
   logic                  k_cur_in_word, k_nxt_in_word;

   logic [WORD_BITS-1:0]  tx_l_q, tx_l_d, tx_r_q, tx_r_d;
   logic [WORD_BITS-1:0]  sh_q, sh_d, sh_in;
   logic [WORD_BITS-1:0]  lhold_q, lhold_d;
   logic [WORD_BITS-1:0]  rx_l_q, rx_l_d, rx_r_q, rx_r_d;
   logic [WORD_BITS-1:0]  dac_word, dac_shift;
   logic                  tx_ready_q, tx_ready_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  dacdat_q, dacdat_d;

   // Counters are cleared whenever we are (or are about to be) idle. On the
   // IDLE->RUN edge they are neither cleared nor advanced, so the first RUN
   // cycle shows ph=0, bc=0 with lrck already low.
   assign clr = rst | ~init_done;
   assign adv = ~clr & (state_q == ST_RUN);

   i2s_bit_timer #(
      .BCLK_DIV  (BCLK_DIV),
      .SLOT_BITS (SLOT_BITS),
      .BC_W      (BC_W)
   ) u_timer (
      .clk_n         (clk_n),
      .rst           (rst),
      .clr_i         (clr),
      .adv_i         (adv),
      .bclk_o        (bclk),
      .lrck_o        (lrck),
      .bc_o          (bc),
      .bc_nxt_o      (bc_nxt),
      .bclk_rise_o   (bclk_rise),
      .bclk_fall_o   (bclk_fall),
      .frame_start_o (frame_start)
   );

   // Slot bit index within the current channel; MSB sits at slot bit 1.
   assign k_cur = (bc >= SLOT_V) ? bc - SLOT_V : bc;
   assign k_nxt = (bc_nxt >= SLOT_V) ? bc_nxt - SLOT_V : bc_nxt;
   assign k_cur_in_word = (k_cur != '0) && (k_cur <= WORD_V);
   assign k_nxt_in_word = (k_nxt != '0) && (k_nxt <= WORD_V);

   assign dac_word  = (bc_nxt >= SLOT_V) ? tx_r_q : tx_l_q;
   assign dac_shift = dac_word >> (WORD_V - k_nxt);
   assign sh_in     = {sh_q[WORD_BITS-2:0], adcdat};

   always_comb begin
      state_d    = state_q;
      tx_l_d     = tx_l_q;
      tx_r_d     = tx_r_q;
      tx_ready_d = 1'b0;
      dacdat_d   = dacdat_q;
      sh_d       = sh_q;
      lhold_d    = lhold_q;
      rx_l_d     = rx_l_q;
      rx_r_d     = rx_r_q;
      rx_valid_d = 1'b0;

      if (!init_done) begin
         // Abort: drop any partial frame, keep the last captured pair.
         state_d  = ST_IDLE;
         dacdat_d = 1'b0;
         sh_d     = '0;
         lhold_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d    = ST_RUN;
               tx_l_d     = smp.tx_left;
               tx_r_d     = smp.tx_right;
               tx_ready_d = 1'b1;
               dacdat_d   = 1'b0;
            end
            ST_RUN: begin
               if (frame_start) begin
                  tx_l_d     = smp.tx_left;
                  tx_r_d     = smp.tx_right;
                  tx_ready_d = 1'b1;
               end
               // The new frame's first data bit (k=1) is one BCLK after the
               // relatch, so dac_word already sees the fresh pair.
               if (bclk_fall) begin
                  dacdat_d = k_nxt_in_word ? dac_shift[0] : 1'b0;
               end
               if (bclk_rise && k_cur_in_word) begin
                  sh_d = sh_in;
                  if (k_cur == WORD_V) begin
                     if (bc < SLOT_V) begin
                        lhold_d = sh_in;
                     end else begin
                        rx_l_d     = lhold_q;
                        rx_r_d     = sh_in;
                        rx_valid_d = 1'b1;
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(negedge clk_n) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tx_l_q     <= '0;
         tx_r_q     <= '0;
         tx_ready_q <= 1'b0;
         dacdat_q   <= 1'b0;
         sh_q       <= '0;
         lhold_q    <= '0;
         rx_l_q     <= '0;
         rx_r_q     <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_l_q     <= tx_l_d;
         tx_r_q     <= tx_r_d;
         tx_ready_q <= tx_ready_d;
         dacdat_q   <= dacdat_d;
         sh_q       <= sh_d;
         lhold_q    <= lhold_d;
         rx_l_q     <= rx_l_d;
         rx_r_q     <= rx_r_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign dacdat       = dacdat_q;
   assign smp.rx_left  = rx_l_q;
   assign smp.rx_right = rx_r_q;
   assign smp.rx_valid = rx_valid_q;
   assign smp.tx_ready = tx_ready_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_i2s_codec_if.sv
// -----------------------------------------------------------------------------
// tb_i2s_codec_if
// Directed bench: an I2S slave codec model drives adcdat and deserialises
// dacdat from the observed bclk/lrck; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_i2s_codec_if;
   import i2s_codec_if_pkg::*;

   // Cycles from the first RUN cycle to the right-slot LSB capture cycle:
   // bc=144 (128+16), ph=3  ->  144*6 + 3.
   localparam int RX_LAT    = 867;
   localparam int FRAME     = 1536;
   localparam int HALF_FRM  = 768;
   localparam int BCLK_PER  = 6;

   // ---------------- clock / reset ----------------
   logic   clk_n = 1'b1;
   logic   rst = 1'b1;
   logic   init_done = 1'b0;
   logic   adcdat = 1'b0;
   wire    bclk, lrck, dacdat;
   state_e dbg_state;

   always #5 clk_n = ~clk_n;

   i2s_codec_if_if #(.WORD_BITS(16)) smp ();

   i2s_codec_if dut (
      .clk_n       (clk_n),
      .rst         (rst),
      .init_done   (init_done),
      .bclk        (bclk),
      .lrck        (lrck),
      .adcdat      (adcdat),
      .dacdat      (dacdat),
      .smp         (smp.master),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;

   int          cyc = 0;
   int          k = 0;
   logic        bclk_p = 1'b0;
   logic        lrck_p = 1'b1;
   logic [15:0] adc_l = 16'h0000;
   logic [15:0] adc_r = 16'h0000;
   logic [15:0] adc_w;
   logic [15:0] dac_sh = 16'h0000;
   logic [15:0] dac_l = 16'h0000;
   logic [15:0] dac_r = 16'h0000;
   int          stray = 0;
   int          rise_cyc = 0, rise_per = 0;
   int          lrck_cyc = 0, lrck_per = 0;
   int          rxv_cnt = 0, rxv_cyc = 0, rxv_per = 0;
   int          txr_cnt = 0, txr_cyc = 0, txr_per = 0;
   logic [15:0] rxv_l = 16'h0000, rxv_r = 16'h0000;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_n);
      #1;
   endtask

   // ---------------- codec model / monitor ----------------
   // Slave-mode codec: a change of lrck restarts its slot bit count at 0,
   // every BCLK falling edge steps it. Data changes after a falling edge and
   // is read by the partner on the rising edge.
   initial begin
      forever begin
         @(posedge clk_n);
         cyc++;
         if (lrck !== lrck_p) k = 0;
         else if (bclk_p === 1'b1 && bclk === 1'b0) k++;

         if (bclk_p === 1'b0 && bclk === 1'b1) begin
            rise_per = cyc - rise_cyc;
            rise_cyc = cyc;
            if (k >= 1 && k <= 16) begin
               dac_sh = {dac_sh[14:0], dacdat};
               if (k == 16) begin
                  if (lrck === 1'b1) dac_r = dac_sh;
                  else               dac_l = dac_sh;
               end
            end else if (dacdat !== 1'b0) begin
               stray++;
            end
         end
         if (lrck !== lrck_p) begin
            lrck_per = cyc - lrck_cyc;
            lrck_cyc = cyc;
         end

         adc_w  = (lrck === 1'b1) ? adc_r : adc_l;
         adcdat = (k >= 1 && k <= 16) ? adc_w[16-k] : 1'b0;

         if (smp.rx_valid === 1'b1) begin
            rxv_cnt++;
            rxv_per = cyc - rxv_cyc;
            rxv_cyc = cyc;
            rxv_l   = smp.rx_left;
            rxv_r   = smp.rx_right;
         end
         if (smp.tx_ready === 1'b1) begin
            txr_cnt++;
            txr_per = cyc - txr_cyc;
            txr_cyc = cyc;
         end
         bclk_p = bclk;
         lrck_p = lrck;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic wait_rxv(input string tag, input int budget);
      int n0 = rxv_cnt;
      int i  = 0;
      while (rxv_cnt == n0 && i < budget) begin
         tick();
         i++;
      end
      check_eq(tag, 32'(rxv_cnt != n0), 32'd1);
   endtask

   task automatic wait_slot(input string tag, input logic want_lrck, input int want_k, input int budget);
      int i = 0;
      while (!(lrck === want_lrck && k == want_k) && i < budget) begin
         tick();
         i++;
      end
      check_eq(tag, 32'(i < budget), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   int viol;
   int t0, t1, t2, n_before;

   initial begin
      smp.tx_left  = 16'h0000;
      smp.tx_right = 16'h0000;

      // Reset held with init_done low.
      viol = 0;
      repeat (20) begin
         tick();
         if (bclk !== 1'b0 || lrck !== 1'b1 || dacdat !== 1'b0 ||
             smp.rx_valid !== 1'b0 || smp.tx_ready !== 1'b0) viol++;
      end
      check_eq("rst_idle_outputs", 32'(viol), 32'd0);
      check_eq("rst_rx_left", {16'h0, smp.rx_left}, 32'h0);
      check_eq("rst_rx_right", {16'h0, smp.rx_right}, 32'h0);
      check_eq("rst_state", {31'h0, dbg_state}, {31'h0, ST_IDLE});

      rst = 1'b0;
      repeat (3) tick();
      check_eq("idle_no_pulses", 32'(rxv_cnt + txr_cnt), 32'd0);

      // Start: first RUN cycle latches tx and shows lrck=0.
      smp.tx_left  = 16'h8001;
      smp.tx_right = 16'h7FFE;
      adc_l = 16'hA5C3;
      adc_r = 16'h1234;
      init_done = 1'b1;
      tick();
      t0 = cyc;
      check_eq("start_tx_ready", {31'h0, smp.tx_ready}, 32'd1);
      check_eq("start_lrck", {31'h0, lrck}, 32'd0);
      check_eq("start_bclk", {31'h0, bclk}, 32'd0);
      check_eq("start_state", {31'h0, dbg_state}, {31'h0, ST_RUN});
      tick();
      check_eq("tx_ready_one_cycle", {31'h0, smp.tx_ready}, 32'd0);

      // First frame.
      wait_rxv("rxv1_seen", 1600);
      check_eq("rxv1_latency", 32'(rxv_cyc - t0), 32'(RX_LAT));
      check_eq("rxv1_left", {16'h0, rxv_l}, 32'hA5C3);
      check_eq("rxv1_right", {16'h0, rxv_r}, 32'h1234);
      check_eq("dac1_left", {16'h0, dac_l}, 32'h8001);
      check_eq("dac1_right", {16'h0, dac_r}, 32'h7FFE);

      // Second frame: cadence.
      wait_rxv("rxv2_seen", 1600);
      check_eq("rxv_period", 32'(rxv_per), 32'(FRAME));
      check_eq("tx_ready_period", 32'(txr_per), 32'(FRAME));
      check_eq("bclk_period", 32'(rise_per), 32'(BCLK_PER));
      check_eq("lrck_half_frame", 32'(lrck_per), 32'(HALF_FRM));
      check_eq("rxv_count", 32'(rxv_cnt), 32'd2);
      check_eq("txr_count", 32'(txr_cnt), 32'd2);
      check_eq("rxv2_left", {16'h0, rxv_l}, 32'hA5C3);
      check_eq("rxv2_right", {16'h0, rxv_r}, 32'h1234);

      // Abort at bc=140 (right slot bit 12) with new ADC words in flight.
      adc_l = 16'h0F0F;
      adc_r = 16'hF0F0;
      wait_slot("reach_bc140", 1'b1, 12, 2000);
      n_before = rxv_cnt;
      init_done = 1'b0;
      tick();
      check_eq("abort_state", {31'h0, dbg_state}, {31'h0, ST_IDLE});
      check_eq("abort_bclk", {31'h0, bclk}, 32'd0);
      check_eq("abort_lrck", {31'h0, lrck}, 32'd1);
      check_eq("abort_dacdat", {31'h0, dacdat}, 32'd0);
      repeat (50) tick();
      check_eq("abort_no_rxv", 32'(rxv_cnt), 32'(n_before));
      check_eq("abort_rx_left_held", {16'h0, smp.rx_left}, 32'hA5C3);
      check_eq("abort_rx_right_held", {16'h0, smp.rx_right}, 32'h1234);

      // Restart from bc=0.
      init_done = 1'b1;
      tick();
      t1 = cyc;
      check_eq("restart_tx_ready", {31'h0, smp.tx_ready}, 32'd1);
      check_eq("restart_lrck", {31'h0, lrck}, 32'd0);
      wait_rxv("rxv3_seen", 1600);
      check_eq("rxv3_latency", 32'(rxv_cyc - t1), 32'(RX_LAT));
      check_eq("rxv3_left", {16'h0, rxv_l}, 32'h0F0F);
      check_eq("rxv3_right", {16'h0, rxv_r}, 32'hF0F0);

      // Reset pulse in the right slot (bc=178).
      smp.tx_left  = 16'h00FF;
      smp.tx_right = 16'hFF00;
      adc_l = 16'h5A3C;
      adc_r = 16'hC3A5;
      wait_slot("reach_bc178", 1'b1, 50, 2000);
      rst = 1'b1;
      tick();
      check_eq("mrst_bclk", {31'h0, bclk}, 32'd0);
      check_eq("mrst_lrck", {31'h0, lrck}, 32'd1);
      check_eq("mrst_dacdat", {31'h0, dacdat}, 32'd0);
      check_eq("mrst_rx_left", {16'h0, smp.rx_left}, 32'h0);
      check_eq("mrst_rx_right", {16'h0, smp.rx_right}, 32'h0);
      check_eq("mrst_rx_valid", {31'h0, smp.rx_valid}, 32'd0);
      check_eq("mrst_tx_ready", {31'h0, smp.tx_ready}, 32'd0);
      check_eq("mrst_state", {31'h0, dbg_state}, {31'h0, ST_IDLE});
      rst   = 1'b0;
      dac_l = 16'h0000;
      dac_r = 16'h0000;
      tick();
      t2 = cyc;
      check_eq("post_rst_tx_ready", {31'h0, smp.tx_ready}, 32'd1);
      wait_rxv("rxv4_seen", 1600);
      check_eq("rxv4_latency", 32'(rxv_cyc - t2), 32'(RX_LAT));
      check_eq("rxv4_left", {16'h0, rxv_l}, 32'h5A3C);
      check_eq("rxv4_right", {16'h0, rxv_r}, 32'hC3A5);
      check_eq("dac4_left", {16'h0, dac_l}, 32'h00FF);
      check_eq("dac4_right", {16'h0, dac_r}, 32'hFF00);

      check_eq("dac_zero_fill", 32'(stray), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
